reg_bank_wb: RTL
================

REG_BANK_WB -- requirements
Module: reg_bank_wb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the register data width.
REQ-002 The block SHALL have parameter SP_INIT, default 227, giving the reset value of register 29.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: a write request this cycle.
REQ-006 The block SHALL have port wr_addr, input, 5 bits: the destination register, driven by the write-destination select mux.
REQ-007 The block SHALL have port wr_data, input, DATA_W bits: the write-back data.
REQ-008 The block SHALL have ports rd_addr_a and rd_addr_b, each input, 5 bits: the read port addresses.
REQ-009 The block SHALL have ports rd_data_a and rd_data_b, each output, DATA_W bits: the read port data.
REQ-010 The block SHALL have port pend_valid, output, 1 bit: the write buffer holds an uncommitted write.
REQ-011 The block SHALL have port pend_addr, output, 5 bits: the destination held in the write buffer.
REQ-012 The block SHALL have port wr_count, output, 16 bits: the number of committed writes.

Function
REQ-013 The block SHALL contain 32 registers of DATA_W bits, plus a one-entry write buffer (pend_valid, pend_addr, pend_data).
REQ-014 Writes are two-stage: at an edge with wr_en=1 and wr_addr!=0, the write SHALL be latched into the buffer (pend_valid=1), not into the array.
REQ-015 At any edge where pend_valid=1, the buffered write SHALL be committed to array[pend_addr], and wr_count SHALL increment by 1.
REQ-016 A commit and a new latch in the same edge SHALL both occur, so back-to-back writes sustain 1 write per cycle with no stall.
REQ-017 At an edge with wr_en=0, or with wr_addr=0, the block SHALL set pend_valid to 0 after any commit; writes to register 0 SHALL be dropped and SHALL NOT be counted.
REQ-018 Reads SHALL be combinational with the following priority:
- rd_addr=0 returns 0;
- else, if pend_valid=1 and pend_addr=rd_addr, returns pend_data;
- else returns array[rd_addr].
REQ-019 There SHALL be no combinational forwarding from wr_data; a write presented in cycle N SHALL be readable from cycle N+1 onward.
REQ-020 Both read ports SHALL be independent; identical addresses SHALL return identical data.
REQ-021 wr_count SHALL wrap from 0xFFFF to 0x0000 on the next commit, with no saturation and no flag.
REQ-022 If the buffered address is rewritten while pending, the older value SHALL commit and the newer value SHALL occupy the buffer; reads SHALL return the newer value.

Reset
REQ-023 With reset=1 at an edge, all registers SHALL become 0, except register 29, which SHALL become SP_INIT.
REQ-024 With reset=1 at an edge, pend_valid=0, pend_addr=0, pend_data=0 and wr_count=0.
REQ-025 Reset SHALL take priority over wr_en and over a pending commit: a buffered write present at a reset edge SHALL be discarded and not counted.
REQ-026 Directly after reset, rd_data for register 29 SHALL read 227 (default), and every other register SHALL read 0.

Verification
REQ-027 Reset, then read registers 0, 29 and 5 -> rd_data = 0, 227, 0; pend_valid=0; wr_count=0.
REQ-028 Write reg 8 = 0xDEADBEEF in cycle N, wr_en=0 afterwards -> at cycle N+1: rd 8 = 0xDEADBEEF via the buffer, pend_valid=1, pend_addr=8; at cycle N+2: pend_valid=0, wr_count=1, rd 8 still 0xDEADBEEF.
REQ-029 Write reg 0 = 0x1234 -> rd 0 = 0, pend_valid stays 0, wr_count unchanged.
REQ-030 Back-to-back writes reg 3 = 1, reg 3 = 2, reg 4 = 3 on consecutive cycles -> after settling: rd 3 = 2, rd 4 = 3, wr_count=3; reads of reg 3 in the middle cycle return the newest value.
REQ-031 Write reg 9 = 0x55, then assert reset on the next edge -> rd 9 = 0, wr_count=0, pend_valid=0.
REQ-032 Preload wr_count to 0xFFFF by 65535 writes, then perform one more committed write -> wr_count=0x0000.

Source files
------------

// File: rtl/reg_bank_wb.sv
// 32-entry register file with a one-entry write-back buffer: writes land in
// the buffer first and commit to the array on the following edge.
module reg_bank_wb #(
  parameter int DATA_W  = 32,
  parameter int SP_INIT = 227
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              pend_valid,
  output logic [4:0]        pend_addr,
  output logic [15:0]       wr_count
);

  logic [DATA_W-1:0] r_mem [32];
  logic              r_pend_valid;
  logic [4:0]        r_pend_addr;
  logic [DATA_W-1:0] r_pend_data;
  logic [15:0]       r_wr_count;
  logic              w_latch;

  assign w_latch = wr_en && (wr_addr != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= (i == 29) ? DATA_W'(SP_INIT) : '0;
      end
      r_pend_valid <= 1'b0;
      r_pend_addr  <= 5'd0;
      r_pend_data  <= '0;
      r_wr_count   <= 16'd0;
    end else begin
      // Commit and new latch may coincide; the array sees the older value.
      if (r_pend_valid) begin
        r_mem[r_pend_addr] <= r_pend_data;
        r_wr_count         <= r_wr_count + 16'd1;
      end
      r_pend_valid <= w_latch;
      if (w_latch) begin
        r_pend_addr <= wr_addr;
        r_pend_data <= wr_data;
      end
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
    logic [DATA_W-1:0] val;
    val = r_mem[addr];
    if (addr == 5'd0) begin
      val = '0;
    end else if (r_pend_valid && (r_pend_addr == addr)) begin
      val = r_pend_data;
    end
    return val;
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
  end

  assign pend_valid = r_pend_valid;
  assign pend_addr  = r_pend_addr;
  assign wr_count   = r_wr_count;

endmodule
